fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 108 ++++++++++
 tb/tb_fetch_queue.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction-byte prefetch queue: streams bytes from a 1-cycle-latency program ROM
// into a small circular buffer that the decoder consumes 1 to 3 bytes at a time.
module fetch_queue #(
    parameter logic [11:0] RESET_ADDR = 12'h000,
    parameter int          DEPTH      = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [11:0] rom_address,
    input  logic [7:0]  rom_data,
    input  logic        flush,
    input  logic [11:0] flush_address,
    input  logic        consume,
    input  logic [1:0]  consume_count,
    output logic [3:0]  valid_count,
    output logic [7:0]  byte0,
    output logic [7:0]  byte1,
    output logic [7:0]  byte2,
    output logic [11:0] pc
);

    localparam int         PW     = $clog2(DEPTH);
    localparam logic [3:0] DEPTH4 = 4'(DEPTH);

    // Every offset added to the head is below DEPTH, so one conditional subtract wraps it.
    function automatic logic [PW-1:0] wrapIdx(input logic [3:0] base, input logic [3:0] off);
        logic [4:0] s;
        s = {1'b0, base} + {1'b0, off};
        if (s >= {1'b0, DEPTH4}) begin
            s = s - {1'b0, DEPTH4};
        end
        return s[PW-1:0];
    endfunction

    logic [11:0]   fetch_addr_q, fetch_addr_d;
    logic [11:0]   pc_q, pc_d;
    logic          pending_q, pending_d;
    logic [3:0]    occ_q, occ_d;
    logic [PW-1:0] head_q, head_d;
    logic [7:0]    buf_q [DEPTH];

    logic          doIssue;
    logic          doWrite;
    logic          doConsume;
    logic [3:0]    inFlight;
    logic [3:0]    consumeAmt;
    logic [PW-1:0] tailIdx;

    always_comb begin
        inFlight   = occ_q + {3'b000, pending_q};
        doIssue    = !flush && (inFlight < DEPTH4);
        doWrite    = !flush && pending_q;
        doConsume  = !flush && consume && (consume_count != 2'd0)
                     && ({2'b00, consume_count} <= occ_q);
        consumeAmt = doConsume ? {2'b00, consume_count} : 4'd0;
        tailIdx    = wrapIdx(4'(head_q), occ_q);

        fetch_addr_d = fetch_addr_q;
        pc_d         = pc_q;
        pending_d    = 1'b0;
        occ_d        = occ_q;
        head_d       = head_q;

        if (flush) begin
            fetch_addr_d = flush_address;
            pc_d         = flush_address;
            occ_d        = 4'd0;
        end else begin
            if (doIssue) begin
                fetch_addr_d = fetch_addr_q + 12'd1;
                pending_d    = 1'b1;
            end
            occ_d  = occ_q + {3'b000, doWrite} - consumeAmt;
            head_d = wrapIdx(4'(head_q), consumeAmt);
            pc_d   = pc_q + {8'd0, consumeAmt};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_addr_q <= RESET_ADDR;
            pc_q         <= RESET_ADDR;
            pending_q    <= 1'b0;
            occ_q        <= 4'd0;
            head_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= 8'h00;
            end
        end else begin
            fetch_addr_q <= fetch_addr_d;
            pc_q         <= pc_d;
            pending_q    <= pending_d;
            occ_q        <= occ_d;
            head_q       <= head_d;
            if (doWrite) begin
                buf_q[tailIdx] <= rom_data;
            end
        end
    end

    assign rom_address = fetch_addr_q;
    assign valid_count = occ_q;
    assign pc          = pc_q;
    assign byte0       = buf_q[wrapIdx(4'(head_q), 4'd0)];
    assign byte1       = buf_q[wrapIdx(4'(head_q), 4'd1)];
    assign byte2       = buf_q[wrapIdx(4'(head_q), 4'd2)];

endmodule

// File: tb/tb_fetch_queue.sv
// Directed-vector bench for fetch_queue, driven by a registered ROM model
// whose contents are memory[a] = a[7:0] ^ 8'h5A.
module tb_fetch_queue;

   typedef struct {
      logic        fl;
      logic [11:0] fa;
      logic        co;
      logic [1:0]  cc;
      logic [11:0] eRom;
      logic [3:0]  eVc;
      logic [11:0] ePc;
      logic [7:0]  eB0;
      logic [7:0]  eB1;
      logic [7:0]  eB2;
   } vec_t;

   logic        clk;
   logic        reset;
   logic [11:0] romAddress;
   logic [7:0]  romData;
   logic        flush;
   logic [11:0] flushAddress;
   logic        consume;
   logic [1:0]  consumeCount;
   logic [3:0]  validCount;
   logic [7:0]  byte0;
   logic [7:0]  byte1;
   logic [7:0]  byte2;
   logic [11:0] pc;

   int   checks;
   int   failures;
   vec_t vecs [28];

   fetch_queue #(.RESET_ADDR(12'h000), .DEPTH(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .rom_address  (romAddress),
      .rom_data     (romData),
      .flush        (flush),
      .flush_address(flushAddress),
      .consume      (consume),
      .consume_count(consumeCount),
      .valid_count  (validCount),
      .byte0        (byte0),
      .byte1        (byte1),
      .byte2        (byte2),
      .pc           (pc)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Program ROM with one cycle of read latency.
   always @(posedge clk) begin
      romData <= romAddress[7:0] ^ 8'h5A;
   end

   // Builds one table record.
   function automatic vec_t mk(input logic fl, input logic [11:0] fa, input logic co,
                               input logic [1:0] cc, input logic [11:0] eRom,
                               input logic [3:0] eVc, input logic [11:0] ePc,
                               input logic [7:0] eB0, input logic [7:0] eB1,
                               input logic [7:0] eB2);
      vec_t v;
      v.fl = fl; v.fa = fa; v.co = co; v.cc = cc;
      v.eRom = eRom; v.eVc = eVc; v.ePc = ePc;
      v.eB0 = eB0; v.eB1 = eB1; v.eB2 = eB2;
      return v;
   endfunction

   // Single comparison with failure report.
   task automatic checkOutput(input string name, input int idx,
                              input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s (vec %0d): got %0h, expected %0h", name, idx, act, exp);
      end
   endtask

   // Drives one vector, clocks one edge, then compares 1 time unit later.
   task automatic applyStimulus(input vec_t v, input int idx);
      flush        = v.fl;
      flushAddress = v.fa;
      consume      = v.co;
      consumeCount = v.cc;
      @(posedge clk);
      #1;
      checkOutput("rom_address", idx, 32'(romAddress), 32'(v.eRom));
      checkOutput("valid_count", idx, 32'(validCount), 32'(v.eVc));
      checkOutput("pc", idx, 32'(pc), 32'(v.ePc));
      if (v.eVc > 4'd0) checkOutput("byte0", idx, 32'(byte0), 32'(v.eB0));
      if (v.eVc > 4'd1) checkOutput("byte1", idx, 32'(byte1), 32'(v.eB1));
      if (v.eVc > 4'd2) checkOutput("byte2", idx, 32'(byte2), 32'(v.eB2));
   endtask

   // All outputs at their reset values.
   task automatic checkResetState(input int idx);
      checkOutput("rst rom_address", idx, 32'(romAddress), 32'h000);
      checkOutput("rst pc", idx, 32'(pc), 32'h000);
      checkOutput("rst valid_count", idx, 32'(validCount), 32'h0);
      checkOutput("rst byte0", idx, 32'(byte0), 32'h00);
      checkOutput("rst byte1", idx, 32'(byte1), 32'h00);
      checkOutput("rst byte2", idx, 32'(byte2), 32'h00);
   endtask

   initial begin
      checks   = 0;
      failures = 0;

      // Fill from reset: bytes 5A 5B 58 59, then idle while full.
      vecs[0]  = mk(0, 12'h000, 0, 2'd0, 12'h001, 4'd0, 12'h000, 8'h00, 8'h00, 8'h00);
      vecs[1]  = mk(0, 12'h000, 0, 2'd0, 12'h002, 4'd1, 12'h000, 8'h5A, 8'h00, 8'h00);
      vecs[2]  = mk(0, 12'h000, 0, 2'd0, 12'h003, 4'd2, 12'h000, 8'h5A, 8'h5B, 8'h00);
      vecs[3]  = mk(0, 12'h000, 0, 2'd0, 12'h004, 4'd3, 12'h000, 8'h5A, 8'h5B, 8'h58);
      vecs[4]  = mk(0, 12'h000, 0, 2'd0, 12'h004, 4'd4, 12'h000, 8'h5A, 8'h5B, 8'h58);
      vecs[5]  = mk(0, 12'h000, 0, 2'd0, 12'h004, 4'd4, 12'h000, 8'h5A, 8'h5B, 8'h58);
      // Consume 2 from full, then refill.
      vecs[6]  = mk(0, 12'h000, 1, 2'd2, 12'h004, 4'd2, 12'h002, 8'h58, 8'h59, 8'h00);
      vecs[7]  = mk(0, 12'h000, 0, 2'd0, 12'h005, 4'd2, 12'h002, 8'h58, 8'h59, 8'h00);
      vecs[8]  = mk(0, 12'h000, 0, 2'd0, 12'h006, 4'd3, 12'h002, 8'h58, 8'h59, 8'h5E);
      vecs[9]  = mk(0, 12'h000, 0, 2'd0, 12'h006, 4'd4, 12'h002, 8'h58, 8'h59, 8'h5E);
      // Steady single-byte consume settles at two valid bytes.
      vecs[10] = mk(0, 12'h000, 1, 2'd1, 12'h006, 4'd3, 12'h003, 8'h59, 8'h5E, 8'h5F);
      vecs[11] = mk(0, 12'h000, 1, 2'd1, 12'h007, 4'd2, 12'h004, 8'h5E, 8'h5F, 8'h00);
      vecs[12] = mk(0, 12'h000, 1, 2'd1, 12'h008, 4'd2, 12'h005, 8'h5F, 8'h5C, 8'h00);
      vecs[13] = mk(0, 12'h000, 1, 2'd1, 12'h009, 4'd2, 12'h006, 8'h5C, 8'h5D, 8'h00);
      vecs[14] = mk(0, 12'h000, 1, 2'd1, 12'h00A, 4'd2, 12'h007, 8'h5D, 8'h52, 8'h00);
      // Oversized consume is ignored but the incoming write lands.
      vecs[15] = mk(0, 12'h000, 1, 2'd3, 12'h00B, 4'd3, 12'h007, 8'h5D, 8'h52, 8'h53);
      // consume_count of zero is no consume.
      vecs[16] = mk(0, 12'h000, 1, 2'd0, 12'h00B, 4'd4, 12'h007, 8'h5D, 8'h52, 8'h53);
      vecs[17] = mk(0, 12'h000, 1, 2'd1, 12'h00B, 4'd3, 12'h008, 8'h52, 8'h53, 8'h50);
      vecs[18] = mk(0, 12'h000, 0, 2'd0, 12'h00C, 4'd3, 12'h008, 8'h52, 8'h53, 8'h50);
      // Flush with a byte in flight, then fetch across the address wrap.
      vecs[19] = mk(1, 12'hFFE, 0, 2'd0, 12'hFFE, 4'd0, 12'hFFE, 8'h00, 8'h00, 8'h00);
      vecs[20] = mk(0, 12'h000, 0, 2'd0, 12'hFFF, 4'd0, 12'hFFE, 8'h00, 8'h00, 8'h00);
      vecs[21] = mk(0, 12'h000, 0, 2'd0, 12'h000, 4'd1, 12'hFFE, 8'hA4, 8'h00, 8'h00);
      vecs[22] = mk(0, 12'h000, 0, 2'd0, 12'h001, 4'd2, 12'hFFE, 8'hA4, 8'hA5, 8'h00);
      vecs[23] = mk(0, 12'h000, 1, 2'd2, 12'h002, 4'd1, 12'h000, 8'h5A, 8'h00, 8'h00);
      vecs[24] = mk(0, 12'h000, 0, 2'd0, 12'h003, 4'd2, 12'h000, 8'h5A, 8'h5B, 8'h00);
      // Flush wins over a same-edge consume.
      vecs[25] = mk(1, 12'h010, 1, 2'd1, 12'h010, 4'd0, 12'h010, 8'h00, 8'h00, 8'h00);
      vecs[26] = mk(0, 12'h000, 0, 2'd0, 12'h011, 4'd0, 12'h010, 8'h00, 8'h00, 8'h00);
      vecs[27] = mk(0, 12'h000, 0, 2'd0, 12'h012, 4'd1, 12'h010, 8'h4A, 8'h00, 8'h00);

      reset        = 1'b1;
      flush        = 1'b0;
      flushAddress = 12'h000;
      consume      = 1'b0;
      consumeCount = 2'd0;
      #2;
      checkResetState(-1);
      #10;
      checkResetState(-2);
      reset = 1'b0;

      for (int i = 0; i < 28; i++) begin
         applyStimulus(vecs[i], i);
      end

      // Sub-cycle reset pulse mid-stream: immediate effect, then identical restart.
      #2;
      reset = 1'b1;
      #1;
      checkResetState(-3);
      #3;
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i], 100 + i);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
